// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60Hz timing constants shared by the sync generator and renderers.
package vga_timing_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_BOTTOM  = 10;
    localparam int V_SYNC    = 2;
    localparam int V_TOP     = 33;

    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int H_MAX        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
    localparam int V_MAX        = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus a registered active-low sync
// strobe decoded from the pre-increment count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX        = H_MAX,
    parameter int SYNC_START = H_SYNC_START,
    parameter int SYNC_END   = H_SYNC_END
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    output logic [9:0] o_count,
    output logic       o_sync_n
);

    logic [9:0] r_count;
    logic       r_sync_n;
    logic       w_wrap;

    assign w_wrap = (r_count == 10'(MAX));

    // Sync decodes every clock, not just on i_en, so the vertical strobe
    // lands one pixel clock after the line change rather than a line later.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count  <= '0;
            r_sync_n <= 1'b1;
        end else begin
            if (i_en)
                r_count <= w_wrap ? '0 : r_count + 10'd1;
            r_sync_n <= ~((r_count >= 10'(SYNC_START)) && (r_count <= 10'(SYNC_END)));
        end
    end

    assign o_count  = r_count;
    assign o_sync_n = r_sync_n;

endmodule

// File: rtl/hvsync_generator.sv
// VGA sync generator: horizontal and vertical axis counters, registered
// active-low syncs and a combinational visible-area flag.
module hvsync_generator #(
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_BOTTOM  = vga_timing_pkg::V_BOTTOM,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_TOP     = vga_timing_pkg::V_TOP
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);

    localparam int HS_START = H_DISPLAY + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int HMAX     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int VS_START = V_DISPLAY + V_BOTTOM;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int VMAX     = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;

    logic [9:0] w_hpos;
    logic [9:0] w_vpos;
    logic       w_h_wrap;

    assign w_h_wrap = (w_hpos == 10'(HMAX));

    vga_axis_counter #(
        .MAX        (HMAX),
        .SYNC_START (HS_START),
        .SYNC_END   (HS_END)
    ) u_h (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_en     (1'b1),
        .o_count  (w_hpos),
        .o_sync_n (hsync)
    );

    // Vertical axis steps once per line, on the horizontal wrap.
    vga_axis_counter #(
        .MAX        (VMAX),
        .SYNC_START (VS_START),
        .SYNC_END   (VS_END)
    ) u_v (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_en     (w_h_wrap),
        .o_count  (w_vpos),
        .o_sync_n (vsync)
    );

    assign hpos       = w_hpos;
    assign vpos       = w_vpos;
    assign display_on = (w_hpos < 10'(H_DISPLAY)) && (w_vpos < 10'(V_DISPLAY));

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator: full-size instance for line timing, a shrunken
// instance for frame-level (vertical, wrap) behaviour within a short run.
module tb_hvsync_generator;
    import vga_timing_pkg::*;

    localparam int SH_D = 10, SH_F = 2, SH_S = 3, SH_B = 3;
    localparam int SV_D = 6,  SV_B = 2, SV_S = 2, SV_T = 3;
    localparam int S_HTOT = SH_D + SH_F + SH_S + SH_B;   // 18
    localparam int S_VTOT = SV_D + SV_B + SV_S + SV_T;   // 13

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       de;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hsync, vsync, display_on;
    logic [9:0] hpos, vpos;
    logic       s_hsync, s_vsync, s_display_on;
    logic [9:0] s_hpos, s_vpos;

    int checks = 0;
    int errors = 0;
    int t = 0;

    obs_t q_big[$];
    obs_t q_sml[$];

    int   big_hs_low, big_de_cnt, sml_vs_low, sml_de_cnt;
    int   big_hs_fall[$];
    int   sml_vs_rise[$];
    logic prev_bhs, prev_svs;

    always #5 clk = ~clk;

    hvsync_generator u_big (
        .clk        (clk),
        .reset      (reset),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .hpos       (hpos),
        .vpos       (vpos)
    );

    hvsync_generator #(
        .H_DISPLAY (SH_D), .H_FRONT (SH_F), .H_SYNC (SH_S), .H_BACK (SH_B),
        .V_DISPLAY (SV_D), .V_BOTTOM (SV_B), .V_SYNC (SV_S), .V_TOP (SV_T)
    ) u_sml (
        .clk        (clk),
        .reset      (reset),
        .hsync      (s_hsync),
        .vsync      (s_vsync),
        .display_on (s_display_on),
        .hpos       (s_hpos),
        .vpos       (s_vpos)
    );

    // Expected outputs t clocks after reset release, from a linear cycle count.
    function automatic obs_t model(int tt, int hd, int hf, int hsw, int hb,
                                   int vd, int vb, int vsw, int vt);
        obs_t o;
        int htot, vtot, h, v, hp, vp;
        htot = hd + hf + hsw + hb;
        vtot = vd + vb + vsw + vt;
        h = tt % htot;
        v = (tt / htot) % vtot;
        o.h  = 10'(h);
        o.v  = 10'(v);
        o.de = (h < hd) && (v < vd);
        if (tt == 0) begin
            o.hs = 1'b1;
            o.vs = 1'b1;
        end else begin
            hp = (tt - 1) % htot;
            vp = ((tt - 1) / htot) % vtot;
            o.hs = !(hp >= hd + hf && hp < hd + hf + hsw);
            o.vs = !(vp >= vd + vb && vp < vd + vb + vsw);
        end
        return o;
    endfunction

    function automatic obs_t big_exp(int tt);
        return model(tt, H_DISPLAY, H_FRONT, H_SYNC, H_BACK, V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP);
    endfunction

    function automatic obs_t sml_exp(int tt);
        return model(tt, SH_D, SH_F, SH_S, SH_B, SV_D, SV_B, SV_S, SV_T);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic cmp_obs(string tag, obs_t got, obs_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0d got h=%0d v=%0d hs=%b vs=%b de=%b exp h=%0d v=%0d hs=%b vs=%b de=%b",
                   tag, t, got.h, got.v, got.hs, got.vs, got.de,
                   exp.h, exp.v, exp.hs, exp.vs, exp.de);
        end
    endtask

    task automatic clear_meas();
        big_hs_low = 0; big_de_cnt = 0; sml_vs_low = 0; sml_de_cnt = 0;
        big_hs_fall.delete();
        sml_vs_rise.delete();
        prev_bhs = 1'b1;
        prev_svs = 1'b1;
    endtask

    // Assert reset between clock edges and check outputs before any edge arrives.
    task automatic do_reset(string tag);
        obs_t rst_exp;
        rst_exp = '{h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1, de: 1'b1};
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        cmp_obs({tag, "_big_async"}, {hpos, vpos, hsync, vsync, display_on}, rst_exp);
        cmp_obs({tag, "_sml_async"}, {s_hpos, s_vpos, s_hsync, s_vsync, s_display_on}, rst_exp);
        @(negedge clk);
        reset = 1'b0;
        t = 0;
        q_big.delete();
        q_sml.delete();
        clear_meas();
        cmp_obs({tag, "_big_rel"}, {hpos, vpos, hsync, vsync, display_on}, big_exp(0));
        cmp_obs({tag, "_sml_rel"}, {s_hpos, s_vpos, s_hsync, s_vsync, s_display_on}, sml_exp(0));
    endtask

    task automatic step(int n);
        obs_t e;
        repeat (n) begin
            q_big.push_back(big_exp(t + 1));
            q_sml.push_back(sml_exp(t + 1));
            @(posedge clk);
            t++;
            @(negedge clk);
            e = q_big.pop_front();
            cmp_obs("big_sb", {hpos, vpos, hsync, vsync, display_on}, e);
            e = q_sml.pop_front();
            cmp_obs("sml_sb", {s_hpos, s_vpos, s_hsync, s_vsync, s_display_on}, e);
            if (!hsync) big_hs_low++;
            if (prev_bhs && !hsync) big_hs_fall.push_back(t);
            prev_bhs = hsync;
            if (display_on) big_de_cnt++;
            if (!s_vsync) sml_vs_low++;
            if (!prev_svs && s_vsync) sml_vs_rise.push_back(t);
            prev_svs = s_vsync;
            if (s_display_on) sml_de_cnt++;
        end
    endtask

    initial begin
        clear_meas();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        do_reset("por");

        // Mid-line reset returns everything to (0,0) without a clock edge.
        step(5);
        do_reset("midline");

        // One full line on the full-size timing.
        step(800);
        chk("line_wrap_h", 32'(hpos), 32'd0);
        chk("line_wrap_v", 32'(vpos), 32'd1);
        chk("hsync_width", 32'(big_hs_low), 32'd96);
        chk("de_per_line", 32'(big_de_cnt), 32'd640);
        step(800);
        chk("hsync_falls", 32'(big_hs_fall.size()), 32'd2);
        if (big_hs_fall.size() == 2) begin
            chk("hsync_first_fall", 32'(big_hs_fall[0]), 32'd657);
            chk("hsync_period", 32'(big_hs_fall[1] - big_hs_fall[0]), 32'd800);
        end

        // Frame-level behaviour on the shrunken instance.
        do_reset("frame");
        step(S_HTOT * S_VTOT);
        chk("frame_wrap_h", 32'(s_hpos), 32'd0);
        chk("frame_wrap_v", 32'(s_vpos), 32'd0);
        chk("de_per_frame", 32'(sml_de_cnt), 32'(SH_D * SV_D));
        step(S_HTOT * S_VTOT + 5);
        chk("vsync_low_2frames", 32'(sml_vs_low), 32'(2 * SV_S * S_HTOT));
        chk("vsync_rises", 32'(sml_vs_rise.size()), 32'd2);
        if (sml_vs_rise.size() == 2)
            chk("vsync_period", 32'(sml_vs_rise[1] - sml_vs_rise[0]), 32'(S_HTOT * S_VTOT));

        // Reset landing mid-frame, then a short resumed run.
        step(100);
        do_reset("midframe");
        step(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
